ram_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the processor's 32×16 single-port data RAM. It shares the RAM between the control unit and a debug/loader port, which can preload or inspect data memory. It serialises their accesses, drives the RAM's write enable, address and data, and returns read data to the requester with a one-cycle acknowledge. Port 0 (control unit) has fixed priority; a starvation counter guarantees port 1 (debug) eventual service.

---
 rtl/ram_arbiter_if.sv | 16 +
 rtl/ram_arbiter.sv | 110 +++++++++++
 tb/tb_ram_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side handshake bundle for ram_arbiter: one instance per port.
// The requester holds req with we/addr/wdata stable until ack pulses.
interface ram_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter and access sequencer for the single-port data RAM.
// Port 0 (uc) has fixed priority; a starvation counter forces a dbg grant after MAX_WAIT contested uc grants.
module ram_arbiter #(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   ram_arbiter_if.slave      uc,
   ram_arbiter_if.slave      dbg,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q,
   output logic              busy,
   output logic              grant
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

   state_t            state;
   logic [3:0]        starve_cnt;
   logic              we_lat;
   logic              ack_uc;
   logic              ack_dbg;
   logic [DATA_W-1:0] rdata_uc;
   logic [DATA_W-1:0] rdata_dbg;
   logic              pick_dbg;

   assign pick_dbg  = dbg.req && (!uc.req || starve_cnt == STARVE_MAX);
   assign uc.ack    = ack_uc;
   assign uc.rdata  = rdata_uc;
   assign dbg.ack   = ack_dbg;
   assign dbg.rdata = rdata_dbg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         starve_cnt  <= '0;
         we_lat      <= 1'b0;
         ack_uc      <= 1'b0;
         ack_dbg     <= 1'b0;
         rdata_uc    <= '0;
         rdata_dbg   <= '0;
         ram_wren    <= 1'b0;
         ram_address <= '0;
         ram_data    <= '0;
         busy        <= 1'b0;
         grant       <= 1'b0;
      end else begin
         ack_uc   <= 1'b0;
         ack_dbg  <= 1'b0;
         ram_wren <= 1'b0;
         case (state)
            IDLE: begin
               if (uc.req || dbg.req) begin
                  grant       <= pick_dbg;
                  we_lat      <= pick_dbg ? dbg.we    : uc.we;
                  ram_wren    <= pick_dbg ? dbg.we    : uc.we;
                  ram_address <= pick_dbg ? dbg.addr  : uc.addr;
                  ram_data    <= pick_dbg ? dbg.wdata : uc.wdata;
                  busy        <= 1'b1;
                  state       <= ISSUE;
                  // Only a contested uc grant counts toward dbg starvation.
                  if (pick_dbg)
                     starve_cnt <= '0;
                  else if (dbg.req && starve_cnt != STARVE_MAX)
                     starve_cnt <= starve_cnt + 4'd1;
               end
            end
            ISSUE: begin
               if (we_lat) begin
                  ack_uc  <= !grant;
                  ack_dbg <= grant;
                  state   <= RESP;
               end else begin
                  state   <= WAIT;
               end
            end
            WAIT: begin
               // ram_q reflects the address presented during ISSUE.
               if (grant)
                  rdata_dbg <= ram_q;
               else
                  rdata_uc  <= ram_q;
               ack_uc  <= !grant;
               ack_dbg <= grant;
               state   <= RESP;
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   a_ack_exclusive : assert property (@(posedge clock) disable iff (reset)
      !(ack_uc && ack_dbg));

   a_wren_only_write : assert property (@(posedge clock) disable iff (reset)
      ram_wren |-> (we_lat && state == ISSUE));

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level reference model, per-cycle compare, directed scenarios.
module tb_ram_arbiter;
   localparam int ADDR_W   = 5;
   localparam int DATA_W   = 16;
   localparam int MAX_WAIT = 4;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              ram_wren;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic [DATA_W-1:0] ram_q;
   logic              busy;
   logic              grant;

   ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) uc_if ();
   ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dbg_if ();

   ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock       (clock),
      .reset       (reset),
      .uc          (uc_if),
      .dbg         (dbg_if),
      .ram_wren    (ram_wren),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_q       (ram_q),
      .busy        (busy),
      .grant       (grant)
   );

   always #5 clock = ~clock;

   // Synchronous-read RAM: q shows the word addressed on the previous edge.
   logic [DATA_W-1:0] ram_mem [32];
   always @(posedge clock) begin
      if (ram_wren) ram_mem[ram_address] <= ram_data;
      ram_q <= ram_mem[ram_address];
   end

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: one transaction record, outputs derived from the cycle offset into it.
   int                cyc = 0;
   int                m_free = 0;
   int                m_starve = 0;
   bit                m_valid = 1'b0;
   int                t_start = 0;
   int                t_len = 3;
   bit                t_port = 1'b0;
   bit                t_we = 1'b0;
   logic [ADDR_W-1:0] t_addr = '0;
   logic [DATA_W-1:0] t_data = '0;
   logic [DATA_W-1:0] m_mem [32];
   logic              e_busy = 1'b0, e_wren = 1'b0, e_ack_uc = 1'b0, e_ack_dbg = 1'b0, e_grant = 1'b0;
   logic [ADDR_W-1:0] e_addr = '0;
   logic [DATA_W-1:0] e_data = '0, e_rd_uc = '0, e_rd_dbg = '0;

   always @(posedge clock or posedge reset) begin
      int c, k;
      bit pick;
      if (reset) begin
         m_valid = 1'b0; m_free = 0; m_starve = 0;
         e_busy = 1'b0; e_wren = 1'b0; e_ack_uc = 1'b0; e_ack_dbg = 1'b0; e_grant = 1'b0;
         e_addr = '0; e_data = '0; e_rd_uc = '0; e_rd_dbg = '0;
      end else begin
         c = cyc;
         if (m_valid && t_we && c == t_start + 1) m_mem[t_addr] = t_data;
         if (c >= m_free && (uc_if.req || dbg_if.req)) begin
            pick = dbg_if.req && (!uc_if.req || m_starve == MAX_WAIT);
            if (pick) m_starve = 0;
            else if (dbg_if.req && m_starve < MAX_WAIT) m_starve = m_starve + 1;
            t_port  = pick;
            t_we    = pick ? dbg_if.we : uc_if.we;
            t_addr  = pick ? dbg_if.addr : uc_if.addr;
            t_data  = pick ? dbg_if.wdata : uc_if.wdata;
            t_start = c;
            t_len   = t_we ? 3 : 4;
            m_free  = c + t_len;
            m_valid = 1'b1;
         end
         cyc = c + 1;
         k = cyc - t_start;
         e_busy    = m_valid && k >= 1 && k < t_len;
         e_wren    = e_busy && t_we && k == 1;
         e_ack_uc  = e_busy && k == t_len - 1 && !t_port;
         e_ack_dbg = e_busy && k == t_len - 1 && t_port;
         if (m_valid && k == 1) begin
            e_addr = t_addr; e_data = t_data; e_grant = t_port;
         end
         if (e_busy && k == t_len - 1 && !t_we) begin
            if (t_port) e_rd_dbg = m_mem[t_addr];
            else        e_rd_uc  = m_mem[t_addr];
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("busy", busy, e_busy);
         chk("grant", grant, e_grant);
         chk("ram_wren", ram_wren, e_wren);
         chk("ram_address", ram_address, e_addr);
         chk("ram_data", ram_data, e_data);
         chk("ack_uc", uc_if.ack, e_ack_uc);
         chk("ack_dbg", dbg_if.ack, e_ack_dbg);
         chk("rdata_uc", uc_if.rdata, e_rd_uc);
         chk("rdata_dbg", dbg_if.rdata, e_rd_dbg);
         chk("ack_overlap", uc_if.ack & dbg_if.ack, 0);
      end
   end

   task automatic set_req(input bit port, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      if (port) begin dbg_if.req = 1'b1; dbg_if.we = we; dbg_if.addr = a; dbg_if.wdata = d; end
      else      begin uc_if.req  = 1'b1; uc_if.we  = we; uc_if.addr  = a; uc_if.wdata  = d; end
   endtask

   task automatic drop(input bit port);
      if (port) dbg_if.req = 1'b0;
      else      uc_if.req  = 1'b0;
   endtask

   task automatic wait_ack(input bit port, output int off, output logic [DATA_W-1:0] rd, output int w);
      off = -1; rd = '0; w = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         if (ram_wren) w++;
         if (port ? dbg_if.ack : uc_if.ack) begin
            off = k;
            rd  = port ? dbg_if.rdata : uc_if.rdata;
            drop(port);
            break;
         end
      end
      if (off < 0) begin
         drop(port);
         chk("ack_timeout", 0, 1);
      end
   endtask

   task automatic txn(input bit port, input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      output int off, output logic [DATA_W-1:0] rd, output int w);
      @(negedge clock); #1;
      set_req(port, we, a, d);
      wait_ack(port, off, rd, w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int off, off2, w, total, n, bad;
      logic [DATA_W-1:0] rd;
      logic [5:0] seq;
      for (int i = 0; i < 32; i++) begin ram_mem[i] = '0; m_mem[i] = '0; end
      uc_if.req = 0; uc_if.we = 0; uc_if.addr = '0; uc_if.wdata = '0;
      dbg_if.req = 0; dbg_if.we = 0; dbg_if.addr = '0; dbg_if.wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk_en = 1'b1;
      chk("por_busy", busy, 0);
      chk("por_grant", grant, 0);
      chk("por_wren", ram_wren, 0);
      chk("por_rdata_uc", uc_if.rdata, 0);

      // Port-0 write then read of address 5.
      txn(0, 1, 5'd5, 16'hABCD, off, rd, w);
      chk("uc_wr_ack_cycle", off, 2);
      chk("uc_wr_wren_pulses", w, 1);
      txn(0, 0, 5'd5, 16'h0000, off, rd, w);
      chk("uc_rd_ack_cycle", off, 3);
      chk("uc_rd_data", rd, 16'hABCD);
      chk("uc_rd_wren_pulses", w, 0);

      // Simultaneous requests: uc read 31 wins, dbg write 0 follows.
      txn(0, 1, 5'd31, 16'h5A5A, off, rd, w);
      @(negedge clock); #1;
      set_req(0, 0, 5'd31, 16'h0000);
      set_req(1, 1, 5'd0, 16'h1234);
      off = -1; off2 = -1; w = 0;
      for (int k = 1; k <= 16 && (off < 0 || off2 < 0); k++) begin
         @(negedge clock);
         if (ram_wren) w++;
         if (uc_if.ack)  begin off = k; rd = uc_if.rdata; drop(0); end
         if (dbg_if.ack) begin off2 = k; drop(1); end
      end
      drop(0); drop(1);
      chk("simul_uc_ack_cycle", off, 3);
      chk("simul_dbg_ack_cycle", off2, 6);
      chk("simul_rdata_uc", rd, 16'h5A5A);
      chk("simul_wren_pulses", w, 1);
      txn(1, 0, 5'd0, 16'h0000, off, rd, w);
      chk("dbg_rd0_data", rd, 16'h1234);

      // Starvation: both held, six grants.
      @(negedge clock); #1;
      set_req(0, 0, 5'd1, 16'h0000);
      set_req(1, 0, 5'd2, 16'h0000);
      seq = '0; n = 0;
      for (int k = 1; k <= 40 && n < 6; k++) begin
         @(negedge clock);
         if (uc_if.ack || dbg_if.ack) begin
            seq[n] = dbg_if.ack;
            n++;
            if (n == 6) begin drop(0); drop(1); end
         end
      end
      drop(0); drop(1);
      chk("starve_ack_count", n, 6);
      chk("starve_grant_seq", seq, 6'b010000);

      // Mid-run reset with both requests low.
      txn(0, 0, 5'd5, 16'h0000, off, rd, w);
      txn(1, 0, 5'd0, 16'h0000, off, rd, w);
      txn(1, 1, 5'd3, 16'h0033, off, rd, w);
      @(negedge clock); #1;
      reset = 1'b1; #1;
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 0);
      chk("rst_addr", ram_address, 0);
      chk("rst_data", ram_data, 0);
      chk("rst_rdata_uc", uc_if.rdata, 0);
      chk("rst_rdata_dbg", dbg_if.rdata, 0);
      @(negedge clock);
      reset = 1'b0;
      bad = 0;
      repeat (5) begin @(negedge clock); if (uc_if.ack || dbg_if.ack || busy) bad++; end
      chk("rst_no_activity", bad, 0);

      // Abort a dbg read during WAIT.
      txn(1, 1, 5'd7, 16'h7777, off, rd, w);
      txn(1, 0, 5'd7, 16'h0000, off, rd, w);
      chk("dbg_rd7_before_abort", rd, 16'h7777);
      @(negedge clock); #1;
      set_req(1, 0, 5'd7, 16'h0000);
      @(negedge clock);
      @(negedge clock);
      chk("abort_in_flight", busy, 1);
      #1 reset = 1'b1; drop(1); #1;
      chk("abort_busy", busy, 0);
      chk("abort_ack_dbg", dbg_if.ack, 0);
      chk("abort_rdata_dbg", dbg_if.rdata, 0);
      @(negedge clock);
      reset = 1'b0;
      bad = 0;
      repeat (4) begin @(negedge clock); if (uc_if.ack || dbg_if.ack) bad++; end
      chk("abort_no_ack", bad, 0);
      txn(1, 0, 5'd7, 16'h0000, off, rd, w);
      chk("abort_reread_cycle", off, 3);
      chk("abort_reread_data", rd, 16'h7777);

      // Abort a dbg write during ISSUE with req held; it restarts after release.
      @(negedge clock); #1;
      set_req(1, 1, 5'd9, 16'h9999);
      @(negedge clock);
      chk("abort_wr_issue_wren", ram_wren, 1);
      #1 reset = 1'b1; #1;
      chk("abort_wr_wren_async", ram_wren, 0);
      @(negedge clock);
      reset = 1'b0;
      wait_ack(1, off, rd, w);
      chk("restart_wr_ack_cycle", off, 2);
      chk("restart_wr_wren", w, 1);
      txn(0, 0, 5'd9, 16'h0000, off, rd, w);
      chk("restart_wr_data", rd, 16'h9999);

      // Back-to-back fill by dbg, readback by uc.
      total = 0;
      for (int a = 0; a < 32; a++) begin
         txn(1, 1, 5'(a), 16'(a * 3), off, rd, w);
         total += w;
      end
      chk("fill_wren_pulses", total, 32);
      for (int a = 0; a < 32; a++) begin
         txn(0, 0, 5'(a), 16'h0000, off, rd, w);
         chk("fill_read_data", rd, 16'(a * 3));
         chk("fill_read_cycle", off, 3);
      end

      repeat (3) @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
